// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO and sequencer that sits directly in front of a UART transmitter.
//   Bytes can be pushed at any rate. They are handed to the transmitter one at a
//   time over the ready/send/finish handshake:
//     - tx_send is raised when a byte is popped.
//     - tx_send is held high until the transmitter drops tx_ready.
//     - The sequencer then waits for tx_finish before the next pop.
//   Every byte therefore produces exactly one tx_send rising edge, and tx_send
//   is low for at least one cycle between bytes.
//
// Parameters
//   DEPTH_LOG2  FIFO depth = 2**DEPTH_LOG2 entries (legal 1..8, default 4)
//
// Ports
//   Clock      in   single clock, all state on posedge
//   Reset      in   synchronous, active-high; abandons any transfer in flight
//   wr_en      in   push wr_data this cycle
//   wr_data    in   [7:0] byte to enqueue
//   full       out  FIFO holds 2**DEPTH_LOG2 entries
//   empty      out  FIFO holds no entries
//   busy       out  FIFO not empty or sequencer not idle
//   tx_ready   in   transmitter idle
//   tx_finish  in   one-cycle pulse, transmitter completed its stop bit
//   tx_send    out  registered send request (level)
//   tx_data    out  [7:0] registered byte, stable while a transfer is active
//
// Optional build macro UART_TXFIFO_STATUS_EN adds:
//   level      out  [DEPTH_LOG2:0] current entry count
//   overflow   out  sticky flag, set by a dropped push
//   ovf_clr    in   clears overflow; a same-cycle dropped push wins
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  input  logic                  tx_ready,
  input  logic                  tx_finish,
  output logic                  tx_send,
  output logic [7:0]            tx_data
`ifdef UART_TXFIFO_STATUS_EN
  ,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  ovf_clr
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [1:0]            state_reg;
  logic                  pop;
  logic                  push;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);
  assign busy  = ~empty | (state_reg != S_IDLE);

  // A pop only happens when the idle sequencer launches a byte.
  assign pop  = (state_reg == S_IDLE) & ~empty & tx_ready;
  // A pop frees a slot in the same cycle, so a push into a full FIFO is still
  // accepted when it coincides with a pop.
  assign push = wr_en & (~full | pop);

  // Storage array: write port only, no reset, so it maps onto block RAM.
  // When full, wr_ptr equals rd_ptr. A simultaneous push+pop therefore reads
  // the old byte (non-blocking semantics) and overwrites it with the new one.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Sequencer. tx_data is the registered read port of the storage array.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      tx_send   <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            tx_data   <= mem[rd_ptr_reg];
            tx_send   <= 1'b1;
            state_reg <= S_SEND;
          end
        end
        S_SEND: begin
          // The transmitter dropping ready means it has taken the byte.
          if (!tx_ready) begin
            tx_send   <= 1'b0;
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_finish) begin
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          tx_send   <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TXFIFO_STATUS_EN
  logic overflow_reg;

  assign level    = count_reg;
  assign overflow = overflow_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      overflow_reg <= 1'b0;
    end else if (wr_en && !push) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end
`endif

endmodule
